a23_run_ctrl: RTL and testbench
===============================

Name: a23_run_ctrl

Overview:
- Run sequencer wrapped around a23_gc_main.
- Accepts a host load stream that fills the code image (p_init) and the two input images (g_init, e_init).
- Holds the core in reset, releases it, counts cycles until terminate or a cycle budget expires, snapshots the output memory image, then streams it out word by word.
- Replaces the bench-level reset/count/dump logic for system-level and FPGA use.

Parameters:
CODE_MEM_SIZE, 512, code image words (p_init)
G_MEM_SIZE, 64, garbler input words (g_init)
E_MEM_SIZE, 64, evaluator input words (e_init)
OUT_MEM_SIZE, 64, output image words (core_o)
RST_CYCLES, 3, cycles core_rst is held high before RUN
MAX_CYCLES, 1000000, RUN cycle budget before timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a run (honoured in IDLE/DONE only)
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted when ld_valid&ld_ready
ld_sel  in  2  0=P, 1=G, 2=E, 3=reserved
ld_addr  in  16  word index within the selected image
ld_data  in  32  word data
ld_err  out  1  sticky: a load was dropped; cleared when start is accepted
core_rst  out  1  reset to a23_gc_main
p_init  out  CODE_MEM_SIZE*32  word i at bits [32i+31:32i]
g_init  out  G_MEM_SIZE*32  same packing
e_init  out  E_MEM_SIZE*32  same packing
core_o  in  OUT_MEM_SIZE*32  core output image
core_terminate  in  1  core done flag
out_valid  out  1  output word valid
out_ready  in  1  output sink ready
out_data  out  32  snapshot word
out_last  out  1  high with the final word
busy  out  1  state is RST_HOLD, RUN or DRAIN
done  out  1  state is DONE
timeout  out  1  run ended by budget; cleared when start is accepted
cycle_count  out  32  RUN cycles in which core_terminate was low

Behaviour:
- Reset values: state=IDLE, core_rst=1, all init images=0, snapshot=0, ld_err=0, timeout=0, cycle_count=0, out_valid=0, out_last=0, out_data=0, done=0, busy=0.
- A reset asserted in any state forces these values on the next edge. A run in progress is abandoned and the images are cleared.
- IDLE / DONE:
  - ld_ready=1, core_rst=1.
  - An accepted word writes image[ld_sel][ld_addr] on the next edge.
  - If ld_sel=3 or ld_addr >= the selected image size, the word is still accepted but dropped, ld_err is set, and no image bit changes.
- start in IDLE/DONE:
  - next state RST_HOLD; clears done, timeout, ld_err and cycle_count.
  - A load accepted in the same cycle is written; images are frozen from then on.
  - Images are retained across runs.
- RST_HOLD:
  - ld_ready=0, core_rst=1 for exactly RST_CYCLES cycles, then RUN.
- RUN:
  - ld_ready=0, core_rst=0.
  - Each cycle with core_terminate=0: cycle_count+1.
  - core_terminate=1: snapshot<=core_o, next state DRAIN, count not incremented.
  - Cycle with core_terminate=0 and cycle_count==MAX_CYCLES-1: count becomes MAX_CYCLES, snapshot<=core_o, timeout<=1, next state DRAIN.
  - Terminate and budget in the same cycle: terminate wins, timeout=0.
- DRAIN:
  - core_rst=1 (core frozen); index starts at 0.
  - out_valid=1, out_data=snapshot[index], out_last=(index==OUT_MEM_SIZE-1).
  - On out_valid&out_ready: index+1. After the last word, next state DONE and out_valid=0.
  - While out_ready=0, out_data and out_last hold stable. start is ignored.
- DONE:
  - done=1; cycle_count and timeout hold until the next start.
- Width rule: cycle_count saturates at 2^32-1; it never wraps.

Test Plan:
1. Load P[0]=0xE3A00001, G[5]=0x12345678, E[63]=0xCAFEBABE; read p_init/g_init/e_init → only those three words are nonzero; ld_err=0.
2. Load sel=3, then sel=1 addr=64 → ld_err=1, images unchanged. Then start → ld_err=0.
3. start with a stub core asserting terminate on the 100th RUN cycle → core_rst high exactly 3 cycles after start, cycle_count=99, timeout=0. Stub core_o word k=k+0x100 → 64 words 0x100..0x13F streamed, out_last only on 0x13F.
4. MAX_CYCLES=50, terminate never asserted → DRAIN entered after 50 RUN cycles, timeout=1, cycle_count=50.
5. DRAIN with out_ready toggling 1-0-0-1 → no word skipped or duplicated; out_data stable while stalled. Then a second start with images retained produces an identical run.
6. Assert rst mid-RUN (cycle 20) → next edge: IDLE, core_rst=1, busy=0, all images 0, out_valid=0.

Source files
------------

// File: rtl/a23_run_ctrl.sv
// rtl/a23_run_ctrl.sv - run sequencer around a23_gc_main
// Loads code/input images, holds and releases core reset, counts the run, then drains the output snapshot.
module a23_run_ctrl #(
   parameter int unsigned CODE_MEM_SIZE = 512,
   parameter int unsigned G_MEM_SIZE    = 64,
   parameter int unsigned E_MEM_SIZE    = 64,
   parameter int unsigned OUT_MEM_SIZE  = 64,
   parameter int unsigned RST_CYCLES    = 3,
   parameter int unsigned MAX_CYCLES    = 1000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic [1:0]                    ld_sel,
   input  logic [15:0]                   ld_addr,
   input  logic [31:0]                   ld_data,
   output logic                          ld_err,
   output logic                          core_rst,
   output logic [CODE_MEM_SIZE*32-1:0]   p_init,
   output logic [G_MEM_SIZE*32-1:0]      g_init,
   output logic [E_MEM_SIZE*32-1:0]      e_init,
   input  logic [OUT_MEM_SIZE*32-1:0]    core_o,
   input  logic                          core_terminate,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   out_data,
   output logic                          out_last,
   output logic                          busy,
   output logic                          done,
   output logic                          timeout,
   output logic [31:0]                   cycle_count
);

   localparam int unsigned PAW = (CODE_MEM_SIZE > 1) ? $clog2(CODE_MEM_SIZE) : 1;
   localparam int unsigned GAW = (G_MEM_SIZE > 1)    ? $clog2(G_MEM_SIZE)    : 1;
   localparam int unsigned EAW = (E_MEM_SIZE > 1)    ? $clog2(E_MEM_SIZE)    : 1;
   localparam int unsigned OAW = (OUT_MEM_SIZE > 1)  ? $clog2(OUT_MEM_SIZE)  : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_HOLD,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CODE_MEM_SIZE*32-1:0] p_q;
   logic [G_MEM_SIZE*32-1:0]    g_q;
   logic [E_MEM_SIZE*32-1:0]    e_q;
   logic [OUT_MEM_SIZE*32-1:0]  snap_q;
   logic [31:0]                 rcnt_q;
   logic [31:0]                 cnt_q;
   logic [OAW-1:0]              idx_q;
   logic                        timeout_q;
   logic                        ld_err_q;

   logic        ld_fire;
   logic        ld_ok;
   logic        start_fire;
   logic [31:0] addr32;

   assign addr32 = {16'd0, ld_addr};

   always_comb begin
      ld_ok = 1'b0;
      case (ld_sel)
         2'd0:    ld_ok = (addr32 < CODE_MEM_SIZE);
         2'd1:    ld_ok = (addr32 < G_MEM_SIZE);
         2'd2:    ld_ok = (addr32 < E_MEM_SIZE);
         default: ld_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ld_ready   = 1'b0;
      core_rst   = 1'b1;
      busy       = 1'b0;
      done       = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_data   = 32'd0;
      start_fire = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            ld_ready   = 1'b1;
            done       = (state_q == S_DONE);
            start_fire = start;
            if (start) state_d = S_RST_HOLD;
         end
         S_RST_HOLD: begin
            busy = 1'b1;
            if (rcnt_q == RST_CYCLES - 1) state_d = S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            core_rst = 1'b0;
            if (core_terminate || (cnt_q == MAX_CYCLES - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = snap_q[{idx_q, 5'd0} +: 32];
            out_last  = (idx_q == OAW'(OUT_MEM_SIZE - 1));
            if (out_ready && out_last) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ld_fire = ld_valid & ld_ready;

   // Images only change while ld_ready is high, so they are frozen for the whole run.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= '0;
         g_q <= '0;
         e_q <= '0;
      end else if (ld_fire && ld_ok) begin
         case (ld_sel)
            2'd0:    p_q[{ld_addr[PAW-1:0], 5'd0} +: 32] <= ld_data;
            2'd1:    g_q[{ld_addr[GAW-1:0], 5'd0} +: 32] <= ld_data;
            2'd2:    e_q[{ld_addr[EAW-1:0], 5'd0} +: 32] <= ld_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt_q    <= 32'd0;
         cnt_q     <= 32'd0;
         idx_q     <= '0;
         timeout_q <= 1'b0;
         ld_err_q  <= 1'b0;
         snap_q    <= '0;
      end else begin
         rcnt_q <= (state_q == S_RST_HOLD) ? rcnt_q + 32'd1 : 32'd0;
         if (state_q == S_DRAIN) begin
            if (out_ready) idx_q <= idx_q + OAW'(1);
         end else begin
            idx_q <= '0;
         end
         if (start_fire) begin
            cnt_q     <= 32'd0;
            timeout_q <= 1'b0;
            ld_err_q  <= 1'b0;
         end
         if (ld_fire && !ld_ok) ld_err_q <= 1'b1;
         // Terminate takes priority over the budget check in the same cycle.
         if (state_q == S_RUN) begin
            if (core_terminate) begin
               snap_q <= core_o;
            end else begin
               if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
               if (cnt_q == MAX_CYCLES - 1) begin
                  snap_q    <= core_o;
                  timeout_q <= 1'b1;
               end
            end
         end
      end
   end

   assign p_init      = p_q;
   assign g_init      = g_q;
   assign e_init      = e_q;
   assign ld_err      = ld_err_q;
   assign timeout     = timeout_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_a23_run_ctrl.sv
// tb/tb_a23_run_ctrl.sv - self-checking bench for a23_run_ctrl
// Directed steps plus random loads/runs, checked against array models of the images and output.
module tb_a23_run_ctrl;

   localparam int CM = 512;
   localparam int GM = 64;
   localparam int EM = 64;
   localparam int OM = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start_a, start_b, ld_valid, out_rdy, core_terminate_a;
   logic [1:0]    ld_sel;
   logic [15:0]   ld_addr;
   logic [31:0]   ld_data;
   logic [OM*32-1:0] core_o;

   logic ld_ready_a, ld_err_a, core_rst_a, out_valid_a, out_last_a, busy_a, done_a, timeout_a;
   logic ld_ready_b, ld_err_b, core_rst_b, out_valid_b, out_last_b, busy_b, done_b, timeout_b;
   logic [31:0] out_data_a, out_data_b, cycle_count_a, cycle_count_b;
   logic [CM*32-1:0] p_init_a, p_init_b;
   logic [GM*32-1:0] g_init_a, g_init_b;
   logic [EM*32-1:0] e_init_a, e_init_b;

   a23_run_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start_a), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
      .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err_a),
      .core_rst(core_rst_a), .p_init(p_init_a), .g_init(g_init_a), .e_init(e_init_a),
      .core_o(core_o), .core_terminate(core_terminate_a), .out_valid(out_valid_a),
      .out_ready(out_rdy), .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a),
      .done(done_a), .timeout(timeout_a), .cycle_count(cycle_count_a)
   );

   a23_run_ctrl #(.MAX_CYCLES(50)) u_dut50 (
      .clk(clk), .rst(rst), .start(start_b), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
      .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err_b),
      .core_rst(core_rst_b), .p_init(p_init_b), .g_init(g_init_b), .e_init(e_init_b),
      .core_o(core_o), .core_terminate(1'b0), .out_valid(out_valid_b),
      .out_ready(out_rdy), .out_data(out_data_b), .out_last(out_last_b), .busy(busy_b),
      .done(done_b), .timeout(timeout_b), .cycle_count(cycle_count_b)
   );

   // Stub core: raises terminate on RUN cycle term_at of the main instance.
   int run_cyc = 0;
   int term_at = 100;
   bit term_en = 1'b0;
   always @(posedge clk) run_cyc <= core_rst_a ? 0 : run_cyc + 1;
   assign core_terminate_a = term_en && !core_rst_a && (run_cyc == term_at - 1);

   bit which = 1'b0;
   wire        m_core_rst  = which ? core_rst_b    : core_rst_a;
   wire        m_out_valid = which ? out_valid_b   : out_valid_a;
   wire [31:0] m_out_data  = which ? out_data_b    : out_data_a;
   wire        m_out_last  = which ? out_last_b    : out_last_a;
   wire        m_busy      = which ? busy_b        : busy_a;
   wire        m_done      = which ? done_b        : done_a;
   wire        m_timeout   = which ? timeout_b     : timeout_a;
   wire        m_ld_err    = which ? ld_err_b      : ld_err_a;
   wire [31:0] m_cycles    = which ? cycle_count_b : cycle_count_a;

   logic [31:0] p_m [CM];
   logic [31:0] g_m [GM];
   logic [31:0] e_m [EM];
   logic [31:0] o_m [OM];
   bit          err_m;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      foreach (p_m[i]) p_m[i] = 32'd0;
      foreach (g_m[i]) g_m[i] = 32'd0;
      foreach (e_m[i]) e_m[i] = 32'd0;
      err_m = 1'b0;
   endtask

   task automatic load(input int s, input int a, input logic [31:0] d);
      ld_valid = 1'b1;
      ld_sel   = 2'(s);
      ld_addr  = 16'(a);
      ld_data  = d;
      @(negedge clk);
      ld_valid = 1'b0;
      if (s == 0 && a < CM)      p_m[a] = d;
      else if (s == 1 && a < GM) g_m[a] = d;
      else if (s == 2 && a < EM) e_m[a] = d;
      else                       err_m = 1'b1;
   endtask

   task automatic check_images();
      for (int i = 0; i < CM; i++) chk("p_init", p_init_a[i*32 +: 32], p_m[i]);
      for (int i = 0; i < GM; i++) chk("g_init", g_init_a[i*32 +: 32], g_m[i]);
      for (int i = 0; i < EM; i++) chk("e_init", e_init_a[i*32 +: 32], e_m[i]);
      chk("ld_err", 32'(ld_err_a), 32'(err_m));
   endtask

   task automatic set_core_o(input bit rnd);
      for (int k = 0; k < OM; k++) begin
         o_m[k] = rnd ? $urandom : 32'(k + 'h100);
         core_o[k*32 +: 32] = o_m[k];
      end
   endtask

   // Starts one instance, measures reset-hold and run length, then drains and checks every word.
   task automatic run(input bit b, input int exp_len, input int mode, input bit exp_to);
      int n, r, k, cyc;
      which = b;
      if (b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (!b) err_m = 1'b0;
      chk("ld_err_after_start", 32'(m_ld_err), 32'd0);
      chk("busy_after_start", 32'(m_busy), 32'd1);
      n = 0;
      while (m_core_rst === 1'b1 && n < 100) begin n++; @(negedge clk); end
      chk("rst_hold_cycles", 32'(n), 32'd3);
      r = 0;
      while (m_core_rst === 1'b0 && r < 5000) begin r++; @(negedge clk); end
      chk("run_cycles", 32'(r), 32'(exp_len));
      chk("cycle_count", m_cycles, exp_to ? 32'(exp_len) : 32'(exp_len - 1));
      chk("timeout", 32'(m_timeout), 32'(exp_to));
      core_o = ~core_o;
      k = 0;
      cyc = 0;
      while (k < OM && cyc < 1000) begin
         if (mode == 0)      out_rdy = 1'b1;
         else if (mode == 1) out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
         else                out_rdy = 1'($urandom_range(0, 1));
         chk("out_valid", 32'(m_out_valid), 32'd1);
         chk("out_data", m_out_data, o_m[k]);
         chk("out_last", 32'(m_out_last), 32'(k == OM - 1));
         if (out_rdy) k++;
         cyc++;
         @(negedge clk);
      end
      out_rdy = 1'b0;
      chk("drain_words", 32'(k), 32'(OM));
      chk("valid_after_drain", 32'(m_out_valid), 32'd0);
      chk("done", 32'(m_done), 32'd1);
      chk("busy_done", 32'(m_busy), 32'd0);
      chk("timeout_held", 32'(m_timeout), 32'(exp_to));
      for (int j = 0; j < OM; j++) core_o[j*32 +: 32] = o_m[j];
   endtask

   initial begin
      int r;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ld_valid = 1'b0; out_rdy = 1'b0;
      ld_sel = 2'd0; ld_addr = 16'd0; ld_data = 32'd0; core_o = '0;
      clear_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_core_rst", 32'(core_rst_a), 32'd1);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_out_valid", 32'(out_valid_a), 32'd0);
      chk("rst_out_data", out_data_a, 32'd0);
      chk("rst_out_last", 32'(out_last_a), 32'd0);
      chk("rst_timeout", 32'(timeout_a), 32'd0);
      chk("rst_cycle_count", cycle_count_a, 32'd0);
      chk("rst_ld_ready", 32'(ld_ready_a), 32'd1);
      check_images();

      // Directed loads
      load(0, 0, 32'hE3A00001);
      load(1, 5, 32'h12345678);
      load(2, 63, 32'hCAFEBABE);
      check_images();

      // Dropped loads
      load(3, 0, 32'hDEADBEEF);
      load(1, 64, 32'h0BADF00D);
      check_images();

      // Random loads, a mix of in-range and out-of-range
      for (int i = 0; i < 60; i++) begin
         int s, a;
         s = $urandom_range(0, 3);
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 700) : $urandom_range(0, 63);
         load(s, a, $urandom);
      end
      check_images();

      // Terminate on RUN cycle 100, incrementing output image
      set_core_o(1'b0);
      term_en = 1'b1;
      term_at = 100;
      run(1'b0, 100, 0, 1'b0);
      check_images();

      // Same run again with a stalling sink, images retained
      run(1'b0, 100, 1, 1'b0);
      check_images();

      // Random terminate point, random output image, random sink
      term_at = $urandom_range(1, 80);
      set_core_o(1'b1);
      run(1'b0, term_at, 2, 1'b0);

      // Budget expiry on the MAX_CYCLES=50 instance
      set_core_o(1'b0);
      run(1'b1, 50, 0, 1'b1);
      which = 1'b0;

      // Reset on RUN cycle 20
      term_en = 1'b0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      r = 0;
      while (core_rst_a === 1'b1 && r < 100) begin r++; @(negedge clk); end
      repeat (19) @(negedge clk);
      chk("mid_run_reached", 32'(core_rst_a), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      chk("mid_rst_core_rst", 32'(core_rst_a), 32'd1);
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
      chk("mid_rst_cycle_count", cycle_count_a, 32'd0);
      chk("mid_rst_ld_ready", 32'(ld_ready_a), 32'd1);
      check_images();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
